// File: rtl/ray_triangle_intersect.sv
// rtl/ray_triangle_intersect.sv - Moller-Trumbore ray/triangle intersection (optional trace port: INTERSECT_TRACE_EN)
`timescale 1ns/1ps
module ray_triangle_intersect #(
  parameter int               WIDTH     = 32,
  parameter int               FRAC_BITS = 28,
  parameter logic [WIDTH-1:0] EPS       = 32'h00000100
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef INTERSECT_TRACE_EN
  input  integer             of,
`endif
  input  logic               start,
  input  logic [6*WIDTH-1:0] r,
  input  logic [9*WIDTH-1:0] trig,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   t,
  output logic [1:0]         code
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] T_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef logic signed [WIDTH-1:0] fx_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CROSS, S_DOT, S_CLASSIFY, S_DIVIDE, S_DONE
  } state_t;

  state_t state;

  fx_t org [3];
  fx_t dir [3];
  fx_t v1  [3];
  fx_t v2  [3];
  fx_t v3  [3];
  fx_t e1  [3];
  fx_t e2  [3];
  fx_t s   [3];
  fx_t p   [3];
  fx_t q   [3];
  fx_t det, un, vn, tn;

  logic [WIDTH-1:0] det_abs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] quo;
  logic             ovf;
  logic [1:0]       res_code;
  logic [CW-1:0]    cnt;

  // Fixed-point product: full signed multiply, keep the Q4.28-aligned window.
  function automatic fx_t fmul(input fx_t a, input fx_t b);
    logic signed [2*WIDTH-1:0] prod;
    prod = a * b;
    return prod[FRAC_BITS+WIDTH-1:FRAC_BITS];
  endfunction

  // Classification values: sign-normalised so det is positive for the tests.
  fx_t              det_abs_c, un_c, vn_c, tn_c;
  logic signed [WIDTH:0] sum_c;
  logic [1:0]       code_c;
  logic [WIDTH-1:0] rem_init_c;
  always_comb begin
    det_abs_c  = det;
    un_c       = un;
    vn_c       = vn;
    tn_c       = tn;
    if (det[WIDTH-1]) begin
      det_abs_c = -det;
      un_c      = -un;
      vn_c      = -vn;
      tn_c      = -tn;
    end
    sum_c      = {un_c[WIDTH-1], un_c} + {vn_c[WIDTH-1], vn_c};
    rem_init_c = $unsigned(tn_c) >> (WIDTH - FRAC_BITS);
    if ($unsigned(det_abs_c) < EPS)
      code_c = 2'd2;
    else if (un_c[WIDTH-1] || vn_c[WIDTH-1] || (sum_c > $signed({1'b0, det_abs_c})))
      code_c = 2'd0;
    else if (tn_c[WIDTH-1] || (tn_c == '0))
      code_c = 2'd3;
    else
      code_c = 2'd1;
  end

  // One restoring-division step and the saturated result value.
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] t_c;
  always_comb begin
    trial  = {rem, dvd[WIDTH-1]};
    q_bit  = (trial >= {1'b0, det_abs});
    rem_nx = q_bit ? WIDTH'(trial - {1'b0, det_abs}) : trial[WIDTH-1:0];
    t_c    = '0;
    if (res_code == 2'd1)
      t_c = (ovf || quo[WIDTH-1]) ? T_MAX : quo;
  end

  // Control FSM and datapath registers, one stage per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      t        <= '0;
      code     <= 2'd0;
      det      <= '0;
      un       <= '0;
      vn       <= '0;
      tn       <= '0;
      det_abs  <= '0;
      rem      <= '0;
      dvd      <= '0;
      quo      <= '0;
      ovf      <= 1'b0;
      res_code <= 2'd0;
      cnt      <= '0;
      for (int k = 0; k < 3; k++) begin
        org[k] <= '0; dir[k] <= '0;
        v1[k]  <= '0; v2[k]  <= '0; v3[k] <= '0;
        e1[k]  <= '0; e2[k]  <= '0; s[k]  <= '0;
        p[k]   <= '0; q[k]   <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 3; k++) begin
              org[k] <= r[(6-k)*WIDTH-1 -: WIDTH];
              dir[k] <= r[(3-k)*WIDTH-1 -: WIDTH];
              v1[k]  <= trig[(9-k)*WIDTH-1 -: WIDTH];
              v2[k]  <= trig[(6-k)*WIDTH-1 -: WIDTH];
              v3[k]  <= trig[(3-k)*WIDTH-1 -: WIDTH];
            end
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          for (int k = 0; k < 3; k++) begin
            e1[k] <= v2[k] - v1[k];
            e2[k] <= v3[k] - v1[k];
            s[k]  <= org[k] - v1[k];
          end
          state <= S_CROSS;
        end
        S_CROSS: begin
          p[0] <= fmul(dir[1], e2[2]) - fmul(dir[2], e2[1]);
          p[1] <= fmul(dir[2], e2[0]) - fmul(dir[0], e2[2]);
          p[2] <= fmul(dir[0], e2[1]) - fmul(dir[1], e2[0]);
          q[0] <= fmul(s[1], e1[2]) - fmul(s[2], e1[1]);
          q[1] <= fmul(s[2], e1[0]) - fmul(s[0], e1[2]);
          q[2] <= fmul(s[0], e1[1]) - fmul(s[1], e1[0]);
          state <= S_DOT;
        end
        S_DOT: begin
          det   <= fmul(e1[0], p[0]) + fmul(e1[1], p[1]) + fmul(e1[2], p[2]);
          un    <= fmul(s[0], p[0]) + fmul(s[1], p[1]) + fmul(s[2], p[2]);
          vn    <= fmul(dir[0], q[0]) + fmul(dir[1], q[1]) + fmul(dir[2], q[2]);
          tn    <= fmul(e2[0], q[0]) + fmul(e2[1], q[1]) + fmul(e2[2], q[2]);
          state <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          res_code <= code_c;
          det_abs  <= det_abs_c;
          // Upper dividend bits seed the remainder; any quotient bit above
          // the 32 we compute means overflow, so flag it up front.
          rem      <= rem_init_c;
          ovf      <= (rem_init_c >= det_abs_c);
          dvd      <= $unsigned(tn_c) << FRAC_BITS;
          quo      <= '0;
          cnt      <= '0;
          state    <= S_DIVIDE;
        end
        S_DIVIDE: begin
          if (res_code == 2'd1) begin
            rem <= rem_nx;
            dvd <= dvd << 1;
            quo <= {quo[WIDTH-2:0], q_bit};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          t     <= t_c;
          code  <= res_code;
`ifdef INTERSECT_TRACE_EN
          $display("det=%h un=%h vn=%h tn=%h code=%h t=%h", det, un, vn, tn, res_code, t_c);
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_triangle_intersect.sv
// tb/tb_ray_triangle_intersect.sv - directed self-checking bench for ray_triangle_intersect
`timescale 1ns/1ps
module tb_ray_triangle_intersect;

  localparam logic [31:0] ZERO  = 32'h00000000;
  localparam logic [31:0] ONE   = 32'h10000000;
  localparam logic [31:0] TWO   = 32'h20000000;
  localparam logic [31:0] HALF  = 32'h08000000;
  localparam logic [31:0] NHALF = 32'hF8000000;
  localparam logic [31:0] NONE  = 32'hF0000000;
  localparam logic [31:0] Z0    = 32'h00083126;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [191:0] r;
  logic [287:0] trig;
  logic         busy;
  logic         done;
  logic [31:0]  t;
  logic [1:0]   code;

  int checks = 0;
  int fails  = 0;

  logic [191:0] ray_alt;
  logic [287:0] tri_alt;
  logic [287:0] tri_c;

  ray_triangle_intersect dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef INTERSECT_TRACE_EN
    .of   (32'h00000001),
`endif
    .start(start),
    .r    (r),
    .trig (trig),
    .busy (busy),
    .done (done),
    .t    (t),
    .code (code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [191:0] mk_ray(input logic [31:0] ox, oy, oz, dx, dy, dz);
    return {ox, oy, oz, dx, dy, dz};
  endfunction

  function automatic logic [287:0] mk_tri(input logic [31:0] ax, ay, az, bx, by, bz, cx, cy, cz);
    return {ax, ay, az, bx, by, bz, cx, cy, cz};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input logic [31:0] tol);
    checks++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Launch one operation; lat = posedges from the sampling edge to done (-1 on timeout).
  // A nonzero poke fires a second start with other vectors while busy.
  task automatic do_op(input logic [191:0] rv, input logic [287:0] tv, input int poke, output int lat);
    lat = -1;
    @(negedge clk);
    r = rv; trig = tv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (poke != 0 && n == poke) begin
        chk("busy_mid_op", {31'b0, busy}, 32'd1);
        r = ray_alt; trig = tri_alt; start = 1'b1;
      end
      if (poke != 0 && n == poke + 1) start = 1'b0;
    end
  endtask

  task automatic op_check(input string tag, input logic [191:0] rv, input logic [287:0] tv,
                          input logic [1:0] exp_code, input logic [31:0] exp_t, input logic [31:0] tol);
    int lat;
    do_op(rv, tv, 0, lat);
    chk({tag, "_latency"}, lat, 32'd37);
    chk({tag, "_code"}, {30'b0, code}, {30'b0, exp_code});
    chk_near({tag, "_t"}, t, exp_t, tol);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int dones;
    rst_n = 1'b0; start = 1'b0; r = '0; trig = '0;
    tri_c   = mk_tri(ZERO, ZERO, ZERO, TWO, ZERO, ZERO, ZERO, TWO, ZERO);
    ray_alt = mk_ray(HALF, HALF, HALF, ZERO, ZERO, NONE);
    tri_alt = tri_c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_t", t, 32'd0);
    chk("rst_code", {30'b0, code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("miss_edge", mk_ray(32'hFFFBE76D, ZERO, Z0, ZERO, ZERO, NONE), tri_c, 2'd0, 32'd0, 32'd0);
    op_check("vertex_hit", mk_ray(ZERO, ZERO, Z0, ZERO, ZERO, NONE), tri_c, 2'd1, 32'h00083126, 32'd2);
    op_check("center_hit", mk_ray(HALF, HALF, HALF, ZERO, ZERO, NONE), tri_c, 2'd1, 32'h08000000, 32'd0);
    op_check("parallel",
             mk_ray(ONE, HALF, HALF, NONE, ZERO, ZERO),
             mk_tri(HALF, HALF, HALF, HALF, ZERO, HALF, ZERO, ZERO, HALF), 2'd2, 32'd0, 32'd0);
    op_check("outside_x", mk_ray(ZERO, HALF, HALF, ONE, 32'h00083127, 32'hFCCCCCCD), tri_c, 2'd0, 32'd0, 32'd0);
    op_check("slant_hit", mk_ray(ZERO, HALF, HALF, HALF, HALF, NHALF), tri_c, 2'd1, 32'h10000000, 32'd0);
    op_check("unit_dir_hit", mk_ray(ZERO, HALF, HALF, 32'h093cd3a0, 32'h093cd3a0, 32'hf6c32c60),
             tri_c, 2'd1, 32'h0DDB3D74, 32'd4);
    op_check("behind", mk_ray(HALF, HALF, NHALF, ZERO, ZERO, NONE), tri_c, 2'd3, 32'd0, 32'd0);
    op_check("neg_det_hit", mk_ray(HALF, HALF, NHALF, ZERO, ZERO, ONE), tri_c, 2'd1, 32'h08000000, 32'd0);

    // Second start while busy, plus input changes after latching: result must be the first op's.
    do_op(mk_ray(ZERO, HALF, HALF, HALF, HALF, NHALF), tri_c, 10, lat);
    chk("busy_start_latency", lat, 32'd37);
    chk("busy_start_code", {30'b0, code}, 32'd1);
    chk("busy_start_t", t, 32'h10000000);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("busy_start_no_second_done", dones, 32'd0);

    // Asynchronous reset in the middle of the division.
    @(negedge clk);
    r = mk_ray(HALF, HALF, HALF, ZERO, ZERO, NONE); trig = tri_c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_t", t, 32'd0);
    chk("abort_code", {30'b0, code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 32'd0);

    op_check("after_abort", mk_ray(HALF, HALF, HALF, ZERO, ZERO, NONE), tri_c, 2'd1, 32'h08000000, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
